// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
package uart_pkg;

    localparam int unsigned DATA_BITS      = 8;
    localparam logic        SYNC_RESET_VAL = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak,
        StParity
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset and a parameterised reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[0], i_d};
        end
    end

    assign o_q = r_sync[1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 serial byte receiver with a valid/ready output and sticky error flags.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds the parity_err output.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_rx_s;
    logic w_cnt_zero;
    logic w_stop_sample;
    logic w_byte_ok;
    logic w_can_load;

    sync_2ff #(
        .RESET_VAL (SYNC_RESET_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;
    assign w_byte_ok  = w_stop_sample && w_rx_s && !r_par_bad;
    assign parity_err = r_parity_err;
`else
    assign w_byte_ok  = w_stop_sample && w_rx_s;
`endif

    assign w_cnt_zero    = (r_cnt == '0);
    assign w_stop_sample = ena && (r_state == StStop) && w_cnt_zero;
    // A new byte may overwrite only a slot that is empty or being drained this cycle.
    assign w_can_load    = !r_rx_valid || rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shreg      <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_byte_ok && w_can_load) begin
                r_rx_data  <= r_shreg;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (err_clr) begin
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end else begin
                if (w_byte_ok && !w_can_load) r_overrun <= 1'b1;
                if (w_stop_sample && !w_rx_s) r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                if (w_stop_sample && w_rx_s && r_par_bad) r_parity_err <= 1'b1;
`endif
            end

            if (!ena) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (!w_rx_s) begin
                            r_state <= StStart;
                            r_cnt   <= HALF_LOAD;
                        end
                    end
                    StStart: begin
                        if (w_cnt_zero) begin
                            if (!w_rx_s) begin
                                r_state   <= StData;
                                r_cnt     <= BIT_LOAD;
                                r_bit_idx <= '0;
                            end else begin
                                r_state <= StIdle;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    StData: begin
                        if (w_cnt_zero) begin
                            r_shreg   <= {w_rx_s, r_shreg[7:1]};
                            r_cnt     <= BIT_LOAD;
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= StParity;
`else
                                r_state <= StStop;
`endif
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (w_cnt_zero) begin
                            r_par_bad <= (^r_shreg) ^ w_rx_s;
                            r_cnt     <= BIT_LOAD;
                            r_state   <= StStop;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
`endif
                    StStop: begin
                        if (w_cnt_zero) begin
                            r_state <= w_rx_s ? StIdle : StBreak;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    StBreak: begin
                        // Held-low line: one frame error, then wait for idle before rearming.
                        if (w_rx_s) r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed self-checking bench for uart_byte_rx at 8 clocks per bit with a byte scoreboard.
module tb_uart_byte_rx;

    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ena      = 1'b1;
    logic       rx_in    = 1'b1;
    logic       rx_ready = 1'b1;
    logic       err_clr  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         t0       = 0;
    logic [7:0] exp_q[$];

    uart_byte_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start + data (+ parity) bits, leaves the stop level on the line and returns.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        @(posedge clk);
        #1 rx_in = 1'b0;
        t0 = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_in = d[i];
            repeat (CPB) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 rx_in = (^d) ^ par_flip;
        repeat (CPB) @(posedge clk);
`else
        if (par_flip) rx_in = d[0];
`endif
        #1 rx_in = stop;
    endtask

    task automatic wait_valid(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    // Pops the next expected byte and compares it with the presented data.
    task automatic score(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, rx_data);
        end else begin
            e = exp_q.pop_front();
            check(tag, rx_data, e);
        end
    endtask

    initial begin
        bit ok;
        bit saw;
        int lat;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Single byte with consumer ready: one-cycle valid pulse at the stated latency
        send_frame(8'hA5, 1'b1, 1'b0);
        exp_q.push_back(8'hA5);
        wait_valid(4 * CPB, ok);
        lat = cyc - t0;
        check("t1_valid_seen", ok, 1);
        check("t1_latency", lat, LAT);
        score("t1_data");
        check("t1_frame_err", frame_err, 0);
        check("t1_overrun", overrun, 0);
        @(negedge clk);
        check("t1_valid_drop", rx_valid, 0);
        repeat (2 * CPB) @(posedge clk);

        // Two bytes back to back with consumer stalled: second is dropped as overrun
        #1 rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        exp_q.push_back(8'h3C);
        repeat (CPB) @(posedge clk);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check("t2_valid_held", rx_valid, 1);
        score("t2_data_held");
        check("t2_overrun_set", overrun, 1);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("t2_valid_after_accept", rx_valid, 0);
        check("t2_overrun_sticky", overrun, 1);
        pulse_clr();
        @(negedge clk);
        check("t2_overrun_cleared", overrun, 0);
        #1 rx_ready = 1'b1;

        // Short low glitch on an idle line
        @(posedge clk);
        #1 rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx_in = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (busy) saw = 1'b1;
        end
        check("t3_busy_pulsed", saw, 1);
        check("t3_busy_idle", busy, 0);
        check("t3_no_valid", rx_valid, 0);
        check("t3_no_frame_err", frame_err, 0);

        // Stop bit held low for 20 bit times, then recovery
        send_frame(8'h55, 1'b0, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 20 * CPB; i++) begin
            @(negedge clk);
            if (rx_valid) saw = 1'b1;
        end
        check("t4_no_valid", saw, 0);
        check("t4_frame_err", frame_err, 1);
        check("t4_busy_break", busy, 1);
        @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("t4_busy_released", busy, 0);
        pulse_clr();
        @(negedge clk);
        check("t4_frame_err_cleared", frame_err, 0);
        send_frame(8'h12, 1'b1, 1'b0);
        exp_q.push_back(8'h12);
        wait_valid(4 * CPB, ok);
        check("t4_valid_seen", ok, 1);
        score("t4_data");
        check("t4_frame_err_clean", frame_err, 0);
        repeat (2 * CPB) @(posedge clk);

        // Enable low: a low line must not start a frame
        #1 ena = 1'b0;
        rx_in = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (busy || rx_valid) saw = 1'b1;
        end
        check("t5_ena_low_idle", saw, 0);
        @(posedge clk);
        #1 rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 ena = 1'b1;
        repeat (4) @(posedge clk);

        // Asynchronous reset mid-frame while a byte is pending
        #1 rx_ready = 1'b0;
        send_frame(8'hC3, 1'b1, 1'b0);
        exp_q.push_back(8'hC3);
        wait_valid(4 * CPB, ok);
        check("t6_pending_seen", ok, 1);
        score("t6_pending_data");
        repeat (2 * CPB) @(posedge clk);
        #1 rx_in = 1'b0;
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        check("t6_busy_before_reset", busy, 1);
        #3 rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_overrun", overrun, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        send_frame(8'h7E, 1'b1, 1'b0);
        exp_q.push_back(8'h7E);
        wait_valid(4 * CPB, ok);
        check("t6_valid_seen", ok, 1);
        score("t6_data");
        check("t6_frame_err", frame_err, 0);
        repeat (2 * CPB) @(posedge clk);

`ifdef UART_RX_PARITY_EN
        // Wrong parity is discarded and flagged; correct parity delivers
        send_frame(8'h03, 1'b1, 1'b1);
        saw = 1'b0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (rx_valid) saw = 1'b1;
        end
        check("t7_no_valid", saw, 0);
        check("t7_parity_err", parity_err, 1);
        pulse_clr();
        @(negedge clk);
        check("t7_parity_cleared", parity_err, 0);
        send_frame(8'h03, 1'b1, 1'b0);
        exp_q.push_back(8'h03);
        wait_valid(4 * CPB, ok);
        check("t7_valid_seen", ok, 1);
        score("t7_data");
        check("t7_parity_clean", parity_err, 0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial receive front end feeding the tt_um_uabc_test2031 core.
- Recovers 8N1 bytes from a dedicated input pin (ui_in[0] at top level) and presents them on a valid/ready byte interface consumed by the core.
- Sits directly upstream of the core logic; the cocotb bench drives it through ui_in.

Parameters:
- CLKS_PER_BIT, 87, clock cycles per bit (10 MHz / 115200); legal range 4..65535.
- CNT_W, 16, width of the bit-timing counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable (tile ena).
- rx_in  input  1  raw asynchronous serial line; idle high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available.
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  sticky; stop bit sampled low.
- overrun  output  1  sticky; a byte completed while the previous byte was unaccepted.
- err_clr  input  1  one-cycle pulse clears frame_err and overrun.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset: async on rst_n low.
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops preset to 1; FSM=IDLE; counters=0.
- rx_in passes a 2-flop synchroniser (rx_s). All timing below is relative to rx_s.
- FSM states:
  - IDLE: on rx_s=0 with ena=1 -> START; load cnt=CLKS_PER_BIT/2-1 (integer division).
  - START: count down. At cnt=0 sample rx_s.
    - 0 -> DATA; cnt=CLKS_PER_BIT-1; bit_idx=0.
    - 1 -> glitch; return to IDLE with no flags.
  - DATA: at each cnt=0, shift rx_s into shreg LSB-first and reload cnt.
    - After bit_idx=7 is sampled -> STOP.
  - STOP: at cnt=0 sample rx_s.
    - 1 -> deliver the byte; go to IDLE.
    - 0 -> set frame_err; discard the byte; go to BREAK.
  - BREAK: wait for rx_s=1, then IDLE. A held-low line yields exactly one frame_err and no repeated frames.
- Delivery, in the cycle after the stop sample:
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load rx_data; rx_valid=1.
  - Otherwise: keep the old rx_data, drop the new byte, set overrun.
- Handshake:
  - rx_valid deasserts the cycle after rx_valid && rx_ready, unless a new byte loads in that same cycle (then rx_valid stays 1).
  - rx_data never changes while rx_valid=1 without a handshake.
- err_clr takes priority over a same-cycle set: the flag clears, and the new event is lost.
- Latency: rx_valid rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx_in falling edge.
- ena=0:
  - FSM forced to IDLE; an in-progress frame is aborted silently.
  - rx_valid, rx_data and flags hold their values; the handshake still works.
- busy=1 in START, DATA, STOP and BREAK.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. A PARITY state follows DATA and samples one bit.
  - On even-parity mismatch, the byte is discarded and a sticky parity_err output is set; err_clr clears it.
  - The parity_err port exists only under the macro.
- Undefined: 8N1 exactly as above; no parity_err port; latency as stated.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, BREAK, PARITY).
  - DATA_BITS=8.
  - SYNC_RESET_VAL=1'b1.
- Sub-module sync_2ff: 2-flop synchroniser with async active-low reset and parameterised reset value.
- FSM, counters and output register stay in uart_byte_rx.

Test Plan:
All scenarios use CLKS_PER_BIT=8.
- Send 0xA5 (8N1, 8 clk/bit) with rx_ready=1 -> rx_valid pulses 1 cycle with rx_data=0xA5, 2+4+72+1=79 cycles after the falling edge; no flags.
- Send 0x3C and 0x81 back-to-back with rx_ready=0 -> rx_data stays 0x3C, rx_valid=1, overrun=1. Then rx_ready=1 -> rx_valid drops; err_clr -> overrun=0.
- 2-cycle low glitch on an idle line -> busy pulses, returns to IDLE; rx_valid=0, frame_err=0.
- Send 0x55 with the stop bit held low for 20 bit times -> frame_err=1 once, no rx_valid. After the line returns high, 0x12 is received correctly.
- Assert rst_n=0 mid-frame, during DATA bit 4 -> all outputs 0 immediately (async). After release, a fresh 0x7E is received intact.
- Under UART_RX_PARITY_EN, send 0x03 with parity bit 1 -> parity_err=1, no rx_valid. With correct parity 0 -> rx_data=0x03.
